// File: rtl/decay_scheduler_if.sv
// Memory and shared-adder bus between the decay scheduler (master)
// and the potential memory / Addition_Subtraction unit (slave).
interface decay_scheduler_if #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [31:0]       mem_rd_data;
    logic              mem_rd_valid;
    logic              mem_wr_en;
    logic [31:0]       mem_wr_data;
    logic [31:0]       add_a;
    logic [31:0]       add_b;
    logic              add_start;
    logic [31:0]       add_result;
    logic              add_valid;

    modport master (
        output mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
        output add_a, add_b, add_start,
        input  mem_rd_data, mem_rd_valid, add_result, add_valid
    );

    modport slave (
        input  mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
        input  add_a, add_b, add_start,
        output mem_rd_data, mem_rd_valid, add_result, add_valid
    );
endinterface

// File: rtl/decay_scheduler.sv
// Walks every neuron once per timestep, decaying its stored float potential
// by a per-neuron power-of-two rate (or x0.75 via the shared adder).
module decay_scheduler #(
    parameter int NUM_NEURONS = 30,
    parameter int ADDR_W      = 5
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 timestep_start,
    input  logic                 cfg_we,
    input  logic [ADDR_W-1:0]    cfg_addr,
    input  logic [3:0]           cfg_rate,
    decay_scheduler_if.master    bus,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun
);

    typedef enum logic [2:0] {
        IDLE, READ, WAIT_RD, DECAY, ADD_REQ, WAIT_ADD, WRITE, DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] index;
    logic [3:0]        cur_rate;
    logic [31:0]       rd_value;
    logic [3:0]        rate_tab [NUM_NEURONS];

    // Exponent-only divide by 2^k; underflow flushes to signed zero, Inf/NaN pass.
    function automatic logic [31:0] decay_value(input logic [31:0] v, input logic [1:0] k);
        logic [7:0] e;
        e = v[30:23];
        if (e == 8'hFF)
            return v;
        else if (e <= {6'b0, k})
            return {v[31], 31'b0};
        else
            return {v[31], e - {6'b0, k}, v[22:0]};
    endfunction

    function automatic logic [1:0] rate_shift(input logic [3:0] r);
        case (r)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state           <= IDLE;
            index           <= '0;
            cur_rate        <= 4'b0001;
            rd_value        <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            overrun         <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_rd_en   <= 1'b0;
            bus.mem_wr_en   <= 1'b0;
            bus.mem_wr_data <= '0;
            bus.add_a       <= '0;
            bus.add_b       <= '0;
            bus.add_start   <= 1'b0;
            for (int i = 0; i < NUM_NEURONS; i++)
                rate_tab[i] <= 4'b0001;
        end else begin
            bus.mem_rd_en <= 1'b0;
            bus.mem_wr_en <= 1'b0;
            bus.add_start <= 1'b0;
            done          <= 1'b0;

            if (cfg_we && (int'(cfg_addr) < NUM_NEURONS))
                rate_tab[cfg_addr] <= cfg_rate;

            // DONE counts as busy for overrun purposes even though busy has dropped.
            if (timestep_start && (state != IDLE))
                overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (timestep_start) begin
                        state         <= READ;
                        busy          <= 1'b1;
                        index         <= '0;
                        bus.mem_addr  <= '0;
                        bus.mem_rd_en <= 1'b1;
                    end
                end
                READ: begin
                    cur_rate <= rate_tab[index];
                    state    <= WAIT_RD;
                end
                WAIT_RD: begin
                    if (bus.mem_rd_valid) begin
                        rd_value <= bus.mem_rd_data;
                        if (cur_rate == 4'b0011) begin
                            bus.add_a     <= decay_value(bus.mem_rd_data, 2'd1);
                            bus.add_b     <= decay_value(bus.mem_rd_data, 2'd2);
                            bus.add_start <= 1'b1;
                            state         <= ADD_REQ;
                        end else begin
                            state <= DECAY;
                        end
                    end
                end
                DECAY: begin
                    bus.mem_wr_data <= decay_value(rd_value, rate_shift(cur_rate));
                    bus.mem_wr_en   <= 1'b1;
                    state           <= WRITE;
                end
                ADD_REQ: begin
                    state <= WAIT_ADD;
                end
                WAIT_ADD: begin
                    if (bus.add_valid) begin
                        bus.mem_wr_data <= bus.add_result;
                        bus.mem_wr_en   <= 1'b1;
                        state           <= WRITE;
                    end
                end
                WRITE: begin
                    if (index == ADDR_W'(NUM_NEURONS - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        index         <= index + 1'b1;
                        bus.mem_addr  <= index + 1'b1;
                        bus.mem_rd_en <= 1'b1;
                        state         <= READ;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/decay_scheduler.md
Name: decay_scheduler

Overview:
- Sequences one shared LIF potential-decay datapath across all neurons of the accelerator once per timestep.
- On each timestep pulse it walks neuron addresses 0..NUM_NEURONS-1. For each neuron it reads the stored IEEE-754 single-precision membrane potential, applies that neuron's programmed decay rate, and writes the result back.
- The divide-by-2-plus-4 rate uses the external shared Addition_Subtraction unit through a start/valid handshake.
- Sits between the timestep generator and the neuron potential memory. Replaces per-neuron free-running set/clear decay control.

Parameters:
- NUM_NEURONS, 30, number of neurons scheduled per timestep.
- ADDR_W, 5, neuron address width (2^ADDR_W >= NUM_NEURONS).

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- timestep_start  in  1  one-cycle pulse that begins a decay sweep.
- cfg_we  in  1  write-enable for the per-neuron decay-rate table.
- cfg_addr  in  ADDR_W  neuron whose rate is written.
- cfg_rate  in  4  decay rate code: 0001 /1, 0010 /2, 0100 /4, 1000 /8, 0011 x0.75 (/2 + /4).
- mem_addr  out  ADDR_W  potential memory address.
- mem_rd_en  out  1  read request, one-cycle pulse.
- mem_rd_data  in  32  potential read data.
- mem_rd_valid  in  1  read data valid; latency is arbitrary but at least 1 cycle.
- mem_wr_en  out  1  write strobe, one-cycle pulse.
- mem_wr_data  out  32  decayed potential.
- add_a  out  32  adder operand (value/2).
- add_b  out  32  adder operand (value/4).
- add_start  out  1  adder request pulse.
- add_result  in  32  adder sum.
- add_valid  in  1  adder result valid.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse when a sweep completes.
- overrun  out  1  sticky flag: timestep_start arrived while busy.

Behaviour:
- Reset (synchronous): all outputs are 0, state IDLE, index 0, every rate entry 4'b0001. RESET overrides everything, including a sweep mid-operation. No write is issued in the reset cycle, and memory contents are left untouched.
- Rate table:
  - A write with cfg_we takes effect at the next edge; cfg_addr >= NUM_NEURONS is ignored.
  - The rate for the current neuron is latched in the READ state. A config write mid-sweep therefore affects only neurons not yet read.
- FSM:
  - IDLE: on timestep_start go to READ; set busy=1, index=0.
  - READ: drive mem_addr=index and pulse mem_rd_en for one cycle, then go to WAIT_RD.
  - WAIT_RD: on mem_rd_valid, capture the data. Go to DECAY for rate 0001/0010/0100/1000 or any undefined code (undefined codes behave as /1). Go to ADD_REQ for 0011.
  - DECAY: compute the result combinationally, register it into mem_wr_data, then go to WRITE.
  - ADD_REQ: drive add_a and add_b, pulse add_start for one cycle, then go to WAIT_ADD.
  - WAIT_ADD: on add_valid, take add_result as the result, then go to WRITE. add_a and add_b stay stable until add_valid.
  - WRITE: pulse mem_wr_en for one cycle with mem_addr=index. If index==NUM_NEURONS-1, go to DONE; otherwise increment index and go to READ.
  - DONE: pulse done for one cycle, set busy=0, go to IDLE.
- Decay arithmetic, with sign s, exponent e and mantissa m, and shift k in {0,1,2,3}:
  - e==8'hFF (Inf/NaN): pass the value through unchanged.
  - e==0 (zero/denormal): output {s, 31'b0}.
  - e<=k: output {s, 31'b0}, i.e. flush underflow to signed zero; the exponent never wraps.
  - Otherwise: output {s, e-k, m}.
  - For rate 0011, add_a is the value shifted by k=1 and add_b by k=2, both under the same rules.
- Timing: a sweep with no x0.75 neurons takes 4+L_rd cycles per neuron plus 2 (start and DONE), where L_rd is the read latency in cycles.
- Overrun: timestep_start while busy=1 sets overrun and is otherwise ignored; the sweep continues. overrun clears only on RESET.
- A timestep_start in the same cycle as the DONE state is treated as an overrun. A new sweep starts only from IDLE.

Test Plan:
- After RESET, write rates all 0001 and memory[0..29]=32'h41DED852, pulse timestep_start → 30 writes, each of 32'h41DED852, in address order 0..29; done pulses once; busy falls on the same edge as done.
- Rate 0100 on neuron 3 with value 32'h41DED852 (27.856) → mem_wr_data 32'h40DED852 at address 3.
- Rate 1000 with value 32'h01800000 (e=3) → write 32'h00000000; value 32'hC1000000 → 32'hBF800000.
- Rate 0011 on neuron 0 with value 32'h41000000 → add_a=32'h40800000, add_b=32'h40000000, add_start pulses once. Hold add_valid low 5 cycles, then return 32'h40C00000 → written value 32'h40C00000, with no mem_wr_en before add_valid.
- timestep_start mid-sweep → overrun=1, sweep finishes all 30 neurons, exactly one done pulse.
- RESET asserted while in WAIT_RD at neuron 10 → next cycle busy=0 and no mem_wr_en; the rate table is back to 0001; a fresh timestep_start sweeps from address 0.
